// File: rtl/uart_pkg.sv
// Shared state encodings and divider helper for the UART transmitter.
// UART_TX_PARITY_EN widens the state to make room for the PARITY phase.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    localparam int STATE_W = 3;
`else
    localparam int STATE_W = 2;
`endif

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t START = state_t'(2'b00);
    localparam state_t DATA  = state_t'(2'b01);
    localparam state_t STOP  = state_t'(2'b10);
    localparam state_t IDLE  = state_t'(2'b11);
`ifdef UART_TX_PARITY_EN
    localparam state_t PARITY = state_t'(3'b100);
`endif

    // Truncating divide: the resulting rate error is accepted by design.
    function automatic int calc_clks_per_bit(input int f, input int baud);
        return f / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick for one cycle on the last clock of each bit
// period and restarts from zero on srst or clear.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign tick = (count_reg == LAST);

    always_comb begin
        count_next = count_reg + CNT_W'(1);
        if (clear || tick) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Free-running 8N1 transmitter: IDLE guard, start, 8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD = 9600,
    parameter int F    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic       tx
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(F, BAUD);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_divider
            $error("uart_tx: F/BAUD must be at least 2");
        end
    endgenerate

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [2:0] bit_idx_reg;
    logic [2:0] bit_idx_next;
    logic       tx_reg;
    logic       tx_next;
    logic       tick;
`ifdef UART_TX_PARITY_EN
    logic       parity_reg;
    logic       parity_next;
`endif

    // Every state change lands on a tick, so this only re-aligns the counter.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .srst (rst),
        .clear(state_next != state_reg),
        .tick (tick)
    );

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        tx_next      = tx_reg;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        if (tick) begin
            case (state_reg)
                IDLE: begin
                    state_next = START;
                    shift_next = data;
                    tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^data;
`endif
                end
                START: begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end
                DATA: begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
`endif
                STOP: begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= 8'h00;
            bit_idx_reg <= 3'd0;
            tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame checks on a 5-clock divider (F=52, BAUD=10)
// plus frame-length checks on a 4-clock divider (F=16, BAUD=4).
module tb_uart_tx;
    import uart_pkg::*;

    localparam int K  = 5;
    localparam int KS = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NPER = 12;
`else
    localparam int NPER = 11;
`endif

    // seq holds the data bits in transmit order, seq[7] going out first.
    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       tx;
    logic       rst_s;
    logic [7:0] data_s;
    logic       tx_s;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    uart_tx #(.BAUD(10), .F(52)) dut (
        .clk (clk),
        .rst (rst),
        .data(data),
        .tx  (tx)
    );

    uart_tx #(.BAUD(4), .F(16)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .data(data_s),
        .tx  (tx_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return v.seq[8 - p];
`ifdef UART_TX_PARITY_EN
        if (p == 9) return v.par;
`endif
        return 1'b1;
    endfunction

    // Starts at the first cycle of a start bit; returns at the next one.
    task automatic check_frame(input vec_t v, input string name);
        for (int p = 0; p < NPER; p++) begin
            int bad = 0;
            logic seen = 1'b0;
            for (int c = 0; c < K; c++) begin
                if (tx !== exp_bit(v, p)) begin
                    bad++;
                    seen = tx;
                end
                @(negedge clk);
            end
            check($sformatf("%s d=%02h period %0d", name, v.data, p),
                  (bad == 0) ? 32'(exp_bit(v, p)) : 32'(seen), 32'(exp_bit(v, p)));
        end
    endtask

    // Called at the negedge where rst is released: K-1 high cycles, then start.
    task automatic check_idle_lead(input string name);
        int bad = 0;
        for (int c = 0; c < K - 1; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check({name, " idle guard low cycles"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({name, " start edge"}, 32'(tx), 32'd0);
    endtask

    vec_t tbl [6];
    vec_t v_d3;
    vec_t v_2c;
    vec_t cur;

    initial begin
        int n_low;
        int n_high;
        int guard;

        v_d3 = '{data: 8'hD3, seq: 8'b1100_1011, par: 1'b1};
        v_2c = '{data: 8'h2C, seq: 8'b0011_0100, par: 1'b1};
        tbl[0] = '{data: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
        tbl[1] = '{data: 8'h07, seq: 8'b1110_0000, par: 1'b1};
        tbl[2] = '{data: 8'h03, seq: 8'b1100_0000, par: 1'b0};
        tbl[3] = '{data: 8'hFF, seq: 8'b1111_1111, par: 1'b0};
        tbl[4] = '{data: 8'h00, seq: 8'b0000_0000, par: 1'b0};
        tbl[5] = '{data: 8'h80, seq: 8'b0000_0001, par: 1'b1};

        rst    = 1'b1;
        data   = 8'hD3;
        rst_s  = 1'b1;
        data_s = 8'h00;

        // Reset hold
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("reset hold tx cyc %0d", i), 32'(tx), 32'd1);
            check($sformatf("reset hold state cyc %0d", i), 32'(dut.state_reg), 32'(IDLE));
        end

        // First frame after release
        rst = 1'b0;
        check_idle_lead("first frame");
        check_frame(v_d3, "frame1");

        // Data change inside the frame in flight goes to the next frame only
        fork
            check_frame(v_d3, "frame2 in flight");
            begin
                repeat (12) @(negedge clk);
                data = 8'h2C;
            end
        join
        cur = v_2c;

        // Table of back-to-back frames
        for (int i = 0; i < 6; i++) begin
            data = tbl[i].data;
            check_frame(cur, $sformatf("table %0d", i));
            cur = tbl[i];
        end
        data = 8'hD3;
        check_frame(cur, "table last");

        // Reset during data bit 3 of a 0xD3 frame
        repeat (4 * K + 2) @(negedge clk);
        check("pre-reset data bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid-frame reset tx", 32'(tx), 32'd1);
        check("mid-frame reset state", 32'(dut.state_reg), 32'(IDLE));
        check("mid-frame reset shift", 32'(dut.shift_reg), 32'd0);
        check("mid-frame reset bit idx", 32'(dut.bit_idx_reg), 32'd0);
        rst = 1'b0;
        check_idle_lead("after reset");
        check_frame(v_d3, "after reset frame");

        // Small divider: low run and fall-to-fall period
        @(negedge clk);
        rst_s = 1'b0;
        guard = 0;
        while (tx_s !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("small div first fall cycle", 32'(guard), 32'(KS));
        n_low = 0;
        while (tx_s === 1'b0 && n_low < 200) begin
            @(negedge clk);
            n_low++;
        end
        n_high = 0;
        while (tx_s !== 1'b0 && n_high < 200) begin
            @(negedge clk);
            n_high++;
        end
`ifdef UART_TX_PARITY_EN
        check("small div low run", 32'(n_low), 32'd40);
        check("small div frame period", 32'(n_low + n_high), 32'd48);
`else
        check("small div low run", 32'(n_low), 32'd36);
        check("small div frame period", 32'(n_low + n_high), 32'd44);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
